// File: rtl/hazard_controller_pkg.sv
// Shared pipeline types for the hazard controller slice: forwarding selects,
// opcode formats and the MEM-wait FSM states.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    EX_MEM = 2'd1,
    MEM_WB = 2'd2
  } FORWARDING_TYPE;

  typedef enum logic [6:0] {
    R_TYPE = 7'b0110011,
    I_TYPE = 7'b0010011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111
  } instruction_format_type;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERR      = 2'd2
  } hazard_state_type;

endpackage

// File: rtl/hazard_controller_forwarding_unit.sv
// EX operand forwarding select: the youngest in-flight writer of a source
// register wins; writes to x0 never forward.
module forwarding_unit
  import hazard_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_mem_rd,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] mem_wb_rd,
  input  logic                      mem_wb_regwrite,
  output FORWARDING_TYPE            forward_a,
  output FORWARDING_TYPE            forward_b
);

  logic ex_valid, wb_valid;

  assign ex_valid = ex_mem_regwrite && (ex_mem_rd != '0);
  assign wb_valid = mem_wb_regwrite && (mem_wb_rd != '0);

  always_comb begin
    forward_a = NONE;
    forward_b = NONE;
    if (ex_valid && (ex_mem_rd == rs1))      forward_a = EX_MEM;
    else if (wb_valid && (mem_wb_rd == rs1)) forward_a = MEM_WB;
    if (ex_valid && (ex_mem_rd == rs2))      forward_b = EX_MEM;
    else if (wb_valid && (mem_wb_rd == rs2)) forward_b = MEM_WB;
  end

endmodule

// File: rtl/hazard_controller.sv
// 5-stage pipeline sequencer: stalls, flushes, forwarding and MEM-wait watchdog.
// Optional perf counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rd,
  input  logic [6:0]                id_ex_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] ex_mem_rd,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] mem_wb_rd,
  input  logic                      mem_wb_regwrite,
  input  logic                      branch_taken,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b,
  output logic                      pc_write_en,
  output logic                      if_id_write_en,
  output logic                      id_ex_write_en,
  output logic                      ex_mem_write_en,
  output logic                      mem_wb_write_en,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      ex_mem_flush,
  output logic                      mem_timeout,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  FORWARDING_TYPE   fwd_a, fwd_b;
  hazard_state_type state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic load_use, freeze;

  forwarding_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_forwarding_unit (
    .rs1             (id_ex_rs1),
    .rs2             (id_ex_rs2),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .forward_a       (fwd_a),
    .forward_b       (fwd_b)
  );

  assign forward_a = fwd_a;
  assign forward_b = fwd_b;

  assign load_use = (id_ex_opcode == LOAD) && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
  assign freeze   = ((state == HZ_RUN) && mem_req && !mem_ready) ||
                    ((state == HZ_MEM_WAIT) && !mem_ready);

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      HZ_RUN: begin
        if (mem_req && !mem_ready) begin
          state_next = HZ_MEM_WAIT;
          wait_next  = '0;
        end
      end
      HZ_MEM_WAIT: begin
        if (mem_ready)                  state_next = HZ_RUN;
        else if (wait_cnt == WAIT_LAST) state_next = HZ_ERR;
        else                            wait_next  = wait_cnt + WAIT_W'(1);
      end
      default: state_next = HZ_RUN;
    endcase
  end

  always_comb begin
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    mem_wb_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_flush    = 1'b0;
    if (reset) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
      ex_mem_flush    = 1'b1;
    end else if (state == HZ_ERR) begin
      pc_write_en     = 1'b0;
      mem_wb_write_en = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
      ex_mem_flush    = 1'b1;
    end else if (freeze) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
    end
  end

  // mem_timeout is set on entry so it is high exactly during the HZ_ERR cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HZ_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_next;
      mem_timeout <= (state_next == HZ_ERR);
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic stall_evt, flush_evt;

  // Counts reflect the action actually applied, so a load-use masked by a branch is not a stall
  assign stall_evt = !reset && (state != HZ_ERR) && (freeze || (!branch_taken && load_use));
  assign flush_evt = !reset && ((state == HZ_ERR) || (!freeze && branch_taken));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_evt && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if (flush_evt && (flush_count != '1))  flush_count  <= flush_count + CNT_WIDTH'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
